// File: rtl/color_cmd_arbiter_pkg.sv
// Shared types and encodings for the color command arbiter: FSM states,
// the command codes sent to the color FSM, and the status codes it returns.
package color_cmd_arbiter_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CHECK = 3'd1,
    ISSUE = 3'd2,
    WAIT  = 3'd3,
    DONE  = 3'd4
  } state_t;

  // Commands driven towards the color FSM
  localparam logic [1:0] CMD_HOLD   = 2'h0;
  localparam logic [1:0] CMD_TOGGLE = 2'h1;

  // Status values reported by the color FSM; anything else is invalid
  localparam logic [1:0] ST_BLUE = 2'h1;
  localparam logic [1:0] ST_RED  = 2'h2;

  // True when the reported status already shows the requested color
  // (color 0 = Blue, 1 = Red). Invalid status never matches.
  function automatic logic status_matches(input logic [1:0] status, input logic color);
    return color ? (status == ST_RED) : (status == ST_BLUE);
  endfunction

endpackage

// File: rtl/color_cmd_arbiter_if.sv
// Bundle of requester handshake and color-FSM command/status signals.
// slave: the arbiter side; master: requesters plus color FSM side.
interface color_cmd_arbiter_if #(
  parameter int NUM_REQ = 4
);

  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ-1:0] req_color;
  logic [NUM_REQ-1:0] ack;
  logic               err;
  logic [1:0]         cmd;
  logic [1:0]         status;
  logic               busy;

  modport slave (
    input  req, req_color, status,
    output ack, err, cmd, busy
  );

  modport master (
    output req, req_color, status,
    input  ack, err, cmd, busy
  );

endinterface

// File: rtl/color_cmd_arbiter_rr_arbiter.sv
// Combinational round-robin picker: given the last granted index, returns
// the first requester found searching from last+1 upward (with wrap).
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  localparam int IDX_W = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last_idx,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               grant_valid
);

  // cand[k] is the requester index at rotation distance k+1 from last_idx
  logic [IDX_W-1:0] cand [NUM_REQ];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_cand
      assign cand[gi] = IDX_W'((int'(last_idx) + gi + 1) % NUM_REQ);
    end
  endgenerate

  // Scan farthest-to-nearest so the nearest active candidate wins
  always_comb begin
    grant_idx   = '0;
    grant_valid = 1'b0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req[cand[i]]) begin
        grant_idx   = cand[i];
        grant_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/color_cmd_arbiter.sv
// Arbitrates requesters that each want the shared color FSM set to a given
// color. The winner's color is compared with the FSM status; if it differs
// a single toggle is issued and the status is watched until it matches or
// the timeout expires. Completion is a one-cycle ack (with err on timeout).
module color_cmd_arbiter
  import color_cmd_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = 8
) (
  input logic                clk,
  input logic                rst_n,
  color_cmd_arbiter_if.slave bus
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT);
  localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(NUM_REQ - 1);

  state_t           state_reg, state_next;
  logic [IDX_W-1:0] winner_reg, winner_next;
  logic             target_reg, target_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             err_flag_reg, err_flag_next;
  logic [IDX_W-1:0] last_reg, last_next;

  logic [NUM_REQ-1:0] req_vec;
  logic [NUM_REQ-1:0] color_vec;
  logic [NUM_REQ-1:0] ack_vec;
  logic [IDX_W-1:0]   rr_idx;
  logic               rr_valid;
  logic               status_hit;
  logic [CNT_W-1:0]   cnt_inc;
  logic [1:0]         cmd_comb;

  assign req_vec   = bus.req;
  assign color_vec = bus.req_color;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_rr (
    .req         (req_vec),
    .last_idx    (last_reg),
    .grant_idx   (rr_idx),
    .grant_valid (rr_valid)
  );

  assign status_hit = status_matches(bus.status, target_reg);
  // Counter saturates rather than wrapping
  assign cnt_inc = (cnt_reg == CNT_MAX) ? CNT_MAX : cnt_reg + 1'b1;

  // State, latched winner/target, timeout counter and rotation pointer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      winner_reg   <= '0;
      target_reg   <= 1'b0;
      cnt_reg      <= '0;
      err_flag_reg <= 1'b0;
      last_reg     <= LAST_RST;
    end else begin
      state_reg    <= state_next;
      winner_reg   <= winner_next;
      target_reg   <= target_next;
      cnt_reg      <= cnt_next;
      err_flag_reg <= err_flag_next;
      last_reg     <= last_next;
    end
  end

  // Next-state and command decode
  always_comb begin
    state_next    = state_reg;
    winner_next   = winner_reg;
    target_next   = target_reg;
    cnt_next      = cnt_reg;
    err_flag_next = err_flag_reg;
    last_next     = last_reg;
    cmd_comb      = CMD_HOLD;
    case (state_reg)
      IDLE: begin
        if (rr_valid) begin
          winner_next   = rr_idx;
          target_next   = color_vec[rr_idx];
          err_flag_next = 1'b0;
          state_next    = CHECK;
        end
      end
      CHECK: begin
        // Invalid status never matches, so it also leads to a toggle
        state_next = status_hit ? DONE : ISSUE;
      end
      ISSUE: begin
        cmd_comb   = CMD_TOGGLE;
        cnt_next   = '0;
        state_next = WAIT;
      end
      WAIT: begin
        if (status_hit) begin
          err_flag_next = 1'b0;
          state_next    = DONE;
        end else begin
          cnt_next = cnt_inc;
          if (cnt_inc == CNT_MAX) begin
            err_flag_next = 1'b1;
            state_next    = DONE;
          end
        end
      end
      DONE: begin
        last_next  = winner_reg;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // One-hot ack decode for the latched winner while in DONE
  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_ack
      assign ack_vec[gi] = (state_reg == DONE) && (winner_reg == IDX_W'(gi));
    end
  endgenerate

  assign bus.ack  = ack_vec;
  assign bus.err  = (state_reg == DONE) && err_flag_reg;
  assign bus.cmd  = cmd_comb;
  assign bus.busy = (state_reg != IDLE);

endmodule

// File: tb/tb_color_cmd_arbiter.sv
// Bench for color_cmd_arbiter: directed scenarios followed by randomized
// rounds, each grant checked cycle by cycle against a transaction-level
// model of arbitration order, latency, toggle pulse and timeout outcome.
module tb_color_cmd_arbiter;

  localparam int N   = 4;
  localparam int TMO = 8;

  logic clk = 1'b0;
  logic rst_n;

  color_cmd_arbiter_if #(.NUM_REQ(N)) bus ();

  color_cmd_arbiter #(
    .NUM_REQ (N),
    .TIMEOUT (TMO)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_checks   = 0;
  int n_fail     = 0;
  int model_last = N - 1;
  int txn        = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_outs(input string ph, input logic [3:0] e_ack, input logic e_err,
                            input logic [1:0] e_cmd, input logic e_busy);
    check_val({ph, " ack"},  32'(bus.ack),  32'(e_ack));
    check_val({ph, " err"},  32'(bus.err),  32'(e_err));
    check_val({ph, " cmd"},  32'(bus.cmd),  32'(e_cmd));
    check_val({ph, " busy"}, 32'(bus.busy), 32'(e_busy));
  endtask

  // First pending requester after the last grant, wrapping around
  function automatic int pick(input logic [3:0] p, input int last);
    for (int s = 1; s <= N; s++) begin
      int i;
      i = (last + s) % N;
      if (((p >> i) & 4'd1) != 4'd0) return i;
    end
    return -1;
  endfunction

  function automatic logic [1:0] enc(input logic c);
    return c ? 2'h2 : 2'h1;
  endfunction

  // One grant starting from an IDLE cycle. d = cycles after the toggle until
  // the color FSM reports the new color (0 = never). abort_off > 0 pulls
  // reset in that cycle offset instead of completing.
  task automatic service(input logic [3:0] req_drv, input logic [3:0] colors,
                         input logic [1:0] st0, input int d, input int abort_off,
                         output int w);
    logic tgt, match, e_err;
    int done_off;
    w = pick(req_drv, model_last);
    @(negedge clk);
    check_outs("idle", 4'b0000, 1'b0, 2'h0, 1'b0);
    bus.req       = req_drv;
    bus.req_color = colors;
    bus.status    = st0;
    if (w < 0) return;
    tgt   = ((colors >> w) & 4'd1) != 4'd0;
    match = (st0 == enc(tgt));
    if (match) begin
      done_off = 2;
      e_err    = 1'b0;
    end else if (d >= 1 && d <= TMO) begin
      done_off = 3 + d;
      e_err    = 1'b0;
    end else begin
      done_off = 3 + TMO;
      e_err    = 1'b1;
    end
    @(negedge clk);
    check_outs("check", 4'b0000, 1'b0, 2'h0, 1'b1);
    for (int off = 2; off <= done_off; off++) begin
      @(negedge clk);
      if (off == abort_off) begin
        #1 rst_n = 1'b0;
        #1;
        check_outs("rst_async", 4'b0000, 1'b0, 2'h0, 1'b0);
        @(negedge clk);
        check_outs("rst_hold", 4'b0000, 1'b0, 2'h0, 1'b0);
        bus.req    = 4'b0000;
        rst_n      = 1'b1;
        model_last = N - 1;
        $display("txn %0d: req %b win %0d aborted by reset at +%0d", txn, req_drv, w, off);
        txn++;
        w = -1;
        return;
      end
      check_outs($sformatf("run%0d", off),
                 (off == done_off) ? (4'b0001 << w) : 4'b0000,
                 (off == done_off) && e_err,
                 (!match && off == 2) ? 2'h1 : 2'h0,
                 1'b1);
      if (!match && d >= 1 && off >= 2 + d) bus.status = enc(tgt);
      if (off == done_off) bus.req = req_drv & ~(4'b0001 << w);
    end
    model_last = w;
    $display("txn %0d: req %b win %0d tgt %0d st0 %0h d %0d ack@+%0d err %0d",
             txn, req_drv, w, tgt, st0, d, done_off, e_err);
    txn++;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int w, d, gap;
    logic [3:0] pend, cols;
    logic [1:0] s0;
    rst_n         = 1'b0;
    bus.req       = 4'b0000;
    bus.req_color = 4'b0000;
    bus.status    = 2'h1;
    repeat (2) @(negedge clk);
    check_outs("reset", 4'b0000, 1'b0, 2'h0, 1'b0);
    rst_n = 1'b1;

    // All four held with matching colors: rotation 0,1,2,3,0 from reset
    for (int k = 0; k < 5; k++) service(4'b1111, 4'b1111, 2'h2, 1, 0, w);

    // Single requesters: match, one-cycle toggle, stuck, timeout boundaries
    service(4'b0001, 4'b0001, 2'h2, 1, 0, w);
    service(4'b0010, 4'b0000, 2'h2, 1, 0, w);
    service(4'b0100, 4'b0000, 2'h2, 0, 0, w);
    service(4'b1000, 4'b0000, 2'h2, TMO, 0, w);
    service(4'b0001, 4'b0000, 2'h2, TMO + 1, 0, w);
    // Invalid status in CHECK forces a toggle
    service(4'b0001, 4'b0001, 2'h3, 1, 0, w);

    // Reset while waiting, then pending requests restart from index 0
    service(4'b0100, 4'b0000, 2'h2, 0, 6, w);
    service(4'b0110, 4'b0000, 2'h1, 1, 0, w);
    service(4'b0100, 4'b0000, 2'h1, 2, 0, w);

    // Randomized rounds of simultaneous requests
    for (int r = 0; r < 40; r++) begin
      pend = 4'($urandom_range(1, 15));
      cols = 4'($urandom);
      gap  = $urandom_range(0, 2);
      repeat (gap) begin
        @(negedge clk);
        check_outs("gap", 4'b0000, 1'b0, 2'h0, 1'b0);
        bus.req = 4'b0000;
      end
      while (pend != 4'b0000) begin
        s0 = 2'($urandom);
        if ($urandom_range(0, 3) == 0) d = 0;
        else d = $urandom_range(1, TMO + 1);
        service(pend, cols, s0, d, 0, w);
        if (w < 0) pend = 4'b0000;
        else pend = pend & ~(4'b0001 << w);
      end
    end

    @(negedge clk);
    check_outs("final", 4'b0000, 1'b0, 2'h0, 1'b0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
